// File: rtl/mining_pkg.sv
// Shared types for the block broadcast bus and per-core job payloads.
package mining_pkg;

    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned HASH_WORDS  = 8;
    localparam int unsigned STATE_BITS  = HASH_WORDS * WORD_BITS;
    localparam int unsigned BCAST_WIDTH = 352;
    localparam int unsigned MAX_TAG_BITS = 16;

    typedef struct packed {
        logic [WORD_BITS-1:0] a;
        logic [WORD_BITS-1:0] b;
        logic [WORD_BITS-1:0] c;
        logic [WORD_BITS-1:0] d;
        logic [WORD_BITS-1:0] e;
        logic [WORD_BITS-1:0] f;
        logic [WORD_BITS-1:0] g;
        logic [WORD_BITS-1:0] h;
    } hash_state_t;

    typedef struct packed {
        hash_state_t           state;
        logic [WORD_BITS-1:0]  w1;
        logic [WORD_BITS-1:0]  w2;
        logic [WORD_BITS-1:0]  w3;
        logic [WORD_BITS-1:0]  nonce;
        logic [MAX_TAG_BITS-1:0] tag;
    } job_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/core_inputs_ifc.sv
// Block broadcast bus shared by all hashing cores.
interface core_inputs_ifc;
    import mining_pkg::*;

    logic                 valid;
    logic                 newblock;
    hash_state_t          hashstate;
    logic [WORD_BITS-1:0] w1;
    logic [WORD_BITS-1:0] w2;
    logic [WORD_BITS-1:0] w3;

    modport reader (input valid, newblock, hashstate, w1, w2, w3);
    modport writer (output valid, newblock, hashstate, w1, w2, w3);
endinterface

// File: rtl/core_input_receiver_nonce_stepper.sv
// Interleaved nonce counter: loads the core index, strides by NCORES, flags the last nonce.
module nonce_stepper #(
    parameter int unsigned NCORES     = 4,
    parameter int unsigned CORE_INDEX = 0,
    parameter int unsigned NONCE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    output logic [NONCE_BITS-1:0] nonce,
    output logic                  last_c
);

    logic [NONCE_BITS:0] sum_c;

    // One extra bit so the carry marks the end of the nonce space.
    assign sum_c  = {1'b0, nonce} + (NONCE_BITS+1)'(NCORES);
    assign last_c = sum_c[NONCE_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nonce <= '0;
        end else if (load) begin
            nonce <= NONCE_BITS'(CORE_INDEX);
        end else if (advance) begin
            nonce <= sum_c[NONCE_BITS-1:0];
        end
    end

endmodule

// File: rtl/core_input_receiver.sv
// Per-core broadcast consumer: captures a new block and issues that core's nonce jobs.
module core_input_receiver
    import mining_pkg::*;
#(
    parameter int unsigned NCORES     = 4,
    parameter int unsigned CORE_INDEX = 0,
    parameter int unsigned NONCE_BITS = 32,
    parameter int unsigned TAG_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    core_inputs_ifc.reader        broadcast,
    input  logic                  core_stall,
    output logic                  job_valid,
    output logic [STATE_BITS-1:0] job_state,
    output logic [WORD_BITS-1:0]  job_w1,
    output logic [WORD_BITS-1:0]  job_w2,
    output logic [WORD_BITS-1:0]  job_w3,
    output logic [WORD_BITS-1:0]  job_nonce,
    output logic [TAG_BITS-1:0]   job_block_id,
    output logic                  exhausted
);

    localparam int unsigned W1_LSB = 2 * WORD_BITS;
    localparam int unsigned W2_LSB = WORD_BITS;

    rx_state_e               state_q;
    rx_state_e               state_d;
    logic                    capture_c;
    logic                    load_c;
    logic                    advance_c;
    logic                    last_c;
    logic [NONCE_BITS-1:0]   nonce_q;
    logic [BCAST_WIDTH-1:0]  active_q;
    logic [TAG_BITS-1:0]     block_id_q;
    logic                    job_valid_q;
    logic                    exhausted_q;

    assign capture_c = broadcast.valid && broadcast.newblock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A capture wins over any same-cycle advance or exhaustion.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        advance_c = 1'b0;
        if (capture_c) begin
            state_d = RUN;
            load_c  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (!core_stall) begin
                        if (last_c) begin
                            state_d = EXHAUSTED;
                        end else begin
                            advance_c = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= '0;
            block_id_q  <= '0;
            job_valid_q <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            job_valid_q <= (state_d == RUN);
            exhausted_q <= (state_d == EXHAUSTED);
            if (capture_c) begin
                active_q   <= {broadcast.hashstate, broadcast.w1, broadcast.w2, broadcast.w3};
                block_id_q <= block_id_q + TAG_BITS'(1);
            end
        end
    end

    nonce_stepper #(
        .NCORES     (NCORES),
        .CORE_INDEX (CORE_INDEX),
        .NONCE_BITS (NONCE_BITS)
    ) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .load    (load_c),
        .advance (advance_c),
        .nonce   (nonce_q),
        .last_c  (last_c)
    );

    assign job_valid    = job_valid_q;
    assign exhausted    = exhausted_q;
    assign job_state    = active_q[BCAST_WIDTH-1 -: STATE_BITS];
    assign job_w1       = active_q[W1_LSB +: WORD_BITS];
    assign job_w2       = active_q[W2_LSB +: WORD_BITS];
    assign job_w3       = active_q[0 +: WORD_BITS];
    assign job_nonce    = WORD_BITS'(nonce_q);
    assign job_block_id = block_id_q;

endmodule
